fft_sdf_stage: RTL

- One radix-2 decimation-in-frequency single-path delay-feedback (SDF) butterfly stage of the 32-point FFT pipeline.
- Five instances are chained, with DELAY = 16, 8, 4, 2, 1. The last instance feeds the bit-reversal sorting stage: out_r/out_i go to its sample inputs and out_sof goes to start_sorting.
- Streaming, one complex sample per accepted cycle, no backpressure. Every stage scales by 1/2 to prevent overflow.

---
 rtl/fft_pkg.sv | 44 ++++
 rtl/fft_cmul.sv | 36 +++
 rtl/fft_sdf_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types, twiddle table and saturation helper.
// Used by the SDF butterfly stages and the bit-reversal sorter.
package fft_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TW_FRAC = 14;
  localparam int TW_W        = 16;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } sample_t;

  typedef logic signed [TW_W-1:0] tw_t;

  // W32^k = c - j*s, Q2.14
  localparam tw_t TW_COS [16] = '{
    16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
    16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
    16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
   -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069
  };

  localparam tw_t TW_SIN [16] = '{
    16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
    16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069,
    16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
    16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196
  };

  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// Complex multiply by W32^k with round-half-up and saturation.
// Purely combinational; the caller registers the result.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TW_FRAC = DEF_TW_FRAC
) (
  input  logic signed [WIDTH-1:0] d_r,
  input  logic signed [WIDTH-1:0] d_i,
  input  logic        [3:0]       k,
  output logic signed [WIDTH-1:0] p_r,
  output logic signed [WIDTH-1:0] p_i
);

  logic signed [63:0] c;
  logic signed [63:0] s;
  logic signed [63:0] ar;
  logic signed [63:0] ai;
  logic signed [63:0] re;
  logic signed [63:0] im;
  logic signed [63:0] half;

  always_comb begin
    c    = 64'(TW_COS[k]);
    s    = 64'(TW_SIN[k]);
    ar   = 64'(d_r);
    ai   = 64'(d_i);
    half = 64'sd1 <<< (TW_FRAC - 1);
    re   = ar * c + ai * s + half;
    im   = ai * c - ar * s + half;
    p_r  = WIDTH'(sat(re >>> TW_FRAC, WIDTH));
    p_i  = WIDTH'(sat(im >>> TW_FRAC, WIDTH));
  end

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage, scaled by 1/2.
// Sums leave in phase B; twiddled differences drain in the next phase A.
module fft_sdf_stage
  import fft_pkg::*;
#(
  parameter int DELAY   = 16,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TW_FRAC = DEF_TW_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic                    flush,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_r,
  output logic signed [WIDTH-1:0] out_i,
  output logic                    out_sof
);

  localparam int CW   = $clog2(2 * DELAY);
  localparam int STEP = 16 / DELAY;
  localparam int W1   = WIDTH + 1;

  logic [CW-1:0] cnt;
  logic          primed;
  logic          phase_b;
  logic          flush_adv;
  logic          adv;
  logic          last_flush;
  logic [3:0]    k;

  logic signed [WIDTH-1:0] x_r, x_i;
  logic signed [WIDTH-1:0] f_r, f_i;
  logic signed [W1-1:0]    s_r, s_i;
  logic signed [W1-1:0]    d_r, d_i;
  logic signed [WIDTH-1:0] sum_r, sum_i;
  logic signed [WIDTH-1:0] dif_r, dif_i;
  logic signed [WIDTH-1:0] tw_r, tw_i;
  logic signed [WIDTH-1:0] push_r, push_i;

  logic signed [WIDTH-1:0] fifo_r [DELAY];
  logic signed [WIDTH-1:0] fifo_i [DELAY];

  always_comb begin
    phase_b    = cnt >= CW'(DELAY);
    flush_adv  = !in_valid && flush && primed && !phase_b;
    adv        = in_valid || flush_adv;
    last_flush = flush_adv && (cnt == CW'(DELAY - 1));
    x_r        = in_valid ? in_r : '0;
    x_i        = in_valid ? in_i : '0;
    f_r        = fifo_r[DELAY-1];
    f_i        = fifo_i[DELAY-1];
    s_r        = W1'(f_r) + W1'(x_r);
    s_i        = W1'(f_i) + W1'(x_i);
    d_r        = W1'(f_r) - W1'(x_r);
    d_i        = W1'(f_i) - W1'(x_i);
    sum_r      = WIDTH'(s_r >>> 1);
    sum_i      = WIDTH'(s_i >>> 1);
    dif_r      = WIDTH'(d_r >>> 1);
    dif_i      = WIDTH'(d_i >>> 1);
    push_r     = phase_b ? dif_r : x_r;
    push_i     = phase_b ? dif_i : x_i;
    k          = 4'(int'(cnt) * STEP);
  end

  fft_cmul #(
    .WIDTH  (WIDTH),
    .TW_FRAC(TW_FRAC)
  ) u_cmul (
    .d_r(f_r),
    .d_i(f_i),
    .k  (k),
    .p_r(tw_r),
    .p_i(tw_i)
  );

  always_ff @(posedge clk) begin
    if (adv) begin
      fifo_r[0] <= push_r;
      fifo_i[0] <= push_i;
      for (int i = 1; i < DELAY; i++) begin
        fifo_r[i] <= fifo_r[i-1];
        fifo_i[i] <= fifo_i[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= adv && (phase_b || primed);
      out_sof   <= adv && (cnt == CW'(DELAY));
      if (adv) begin
        out_r <= phase_b ? sum_r : tw_r;
        out_i <= phase_b ? sum_i : tw_i;
        if (last_flush) begin
          cnt    <= '0;
          primed <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (phase_b) primed <= 1'b1;
      end
    end
  end

endmodule
